// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding, opcodes,
// datapath select encodings and the decoded control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StRWb      = 4'd7,
    StExecI    = 4'd8,
    StIWb      = 4'd9,
    StBranch   = 4'd10,
    StJump     = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  localparam logic [1:0] PcAluResult = 2'b00;
  localparam logic [1:0] PcAluOut    = 2'b01;
  localparam logic [1:0] PcJump      = 2'b10;

  // Moore control word; the *_on_ready flags mark enables the top gates with mem_ready.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       fetch_on_ready;
    logic       done_on_ready;
    logic       mem_wait;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OpLw) || (op == OpSw);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Purely combinational state-to-control-word decoder for the multicycle controller.
module multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      StFetch: begin
        o_ctrl.mem_read       = 1'b1;
        o_ctrl.alu_src_b      = SrcBFour;
        o_ctrl.alu_op         = AluAdd;
        o_ctrl.pc_source      = PcAluResult;
        o_ctrl.fetch_on_ready = 1'b1;
        o_ctrl.mem_wait       = 1'b1;
      end
      StDecode: begin
        // Branch target is computed speculatively into ALU out.
        o_ctrl.alu_src_b = SrcBImmSh2;
        o_ctrl.alu_op    = AluAdd;
      end
      StMemAddr: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SrcBImm;
        o_ctrl.alu_op    = AluAdd;
      end
      StMemRead: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
        o_ctrl.mem_wait = 1'b1;
      end
      StMemWrite: begin
        o_ctrl.mem_write     = 1'b1;
        o_ctrl.i_or_d        = 1'b1;
        o_ctrl.done_on_ready = 1'b1;
        o_ctrl.mem_wait      = 1'b1;
      end
      StMemWb: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      StExecR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SrcBReg;
        o_ctrl.alu_op    = AluFunct;
      end
      StRWb: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      StExecI: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SrcBImm;
        o_ctrl.alu_op    = AluAdd;
      end
      StIWb: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      StBranch: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SrcBReg;
        o_ctrl.alu_op        = AluSub;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PcAluOut;
        o_ctrl.instr_done    = 1'b1;
      end
      StJump: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PcJump;
        o_ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: state register, memory wait counter with timeout,
// ready-gated enables and reset gating of every output.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_fault,
  output logic [3:0] state
);

  localparam logic [3:0] WaitMax = 4'(WAIT_LIMIT);

  state_e     r_state_q, w_state_d;
  logic [3:0] r_wait_q, w_wait_d;
  ctrl_t      w_ctrl;
  logic       w_timeout;
  logic       w_illegal;

  multicycle_ctrl_decode u_decode (
    .i_state (r_state_q),
    .o_ctrl  (w_ctrl)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_q <= StFetch;
      r_wait_q  <= '0;
    end else begin
      r_state_q <= w_state_d;
      r_wait_q  <= w_wait_d;
    end
  end

  always_comb begin
    w_state_d = r_state_q;
    w_wait_d  = '0;
    w_illegal = 1'b0;
    // A ready arriving on the limit cycle wins over the timeout.
    w_timeout = w_ctrl.mem_wait && !mem_ready && (r_wait_q == WaitMax);

    case (r_state_q)
      StFetch:    if (mem_ready) w_state_d = StDecode;
      StDecode: begin
        if (is_mem_op(opcode)) begin
          w_state_d = StMemAddr;
        end else begin
          case (opcode)
            OpRtype: w_state_d = StExecR;
            OpAddi:  w_state_d = StExecI;
            OpBeq:   w_state_d = StBranch;
            OpJ:     w_state_d = StJump;
            default: begin
              w_state_d = StFetch;
              w_illegal = 1'b1;
            end
          endcase
        end
      end
      StMemAddr:  w_state_d = (opcode == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) w_state_d = StMemWb;
      StMemWrite: if (mem_ready) w_state_d = StFetch;
      StExecR:    w_state_d = StRWb;
      StExecI:    w_state_d = StIWb;
      default:    w_state_d = StFetch;
    endcase

    if (w_timeout) w_state_d = StFetch;

    // Counter only survives while stalling in the same wait state; any exit clears it.
    if (w_ctrl.mem_wait && !mem_ready && !w_timeout) w_wait_d = r_wait_q + 4'd1;
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    mem_fault     = 1'b0;
    state         = 4'd0;
    if (!reset) begin
      pc_write      = w_ctrl.pc_write | (w_ctrl.fetch_on_ready & mem_ready);
      pc_write_cond = w_ctrl.pc_write_cond;
      i_or_d        = w_ctrl.i_or_d;
      mem_read      = w_ctrl.mem_read;
      mem_write     = w_ctrl.mem_write;
      ir_write      = w_ctrl.fetch_on_ready & mem_ready;
      mem_to_reg    = w_ctrl.mem_to_reg;
      reg_dst       = w_ctrl.reg_dst;
      reg_write     = w_ctrl.reg_write;
      alu_src_a     = w_ctrl.alu_src_a;
      alu_src_b     = w_ctrl.alu_src_b;
      alu_op        = w_ctrl.alu_op;
      pc_source     = w_ctrl.pc_source;
      instr_done    = w_ctrl.instr_done | (w_ctrl.done_on_ready & mem_ready);
      illegal_op    = w_illegal;
      mem_fault     = w_timeout;
      state         = r_state_q;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench: per-instruction expectations from an instruction-level model.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clock, reset, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op, mem_fault;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  multicycle_control #(.WAIT_LIMIT(15)) dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .mem_fault     (mem_fault),
    .state         (state)
  );

  logic [22:0] outs;
  assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
                 illegal_op, mem_fault, state};

  typedef struct {
    int ev; int cycles; int mem_read; int i_or_d; int mem_write; int ir_write; int pc_write;
    int pc_write_cond; int reg_write; int mem_to_reg; int reg_dst; int alu_src_a;
    int src_b; int alu_op; int pc_src; int last_state;
  } rec_t;

  rec_t q[$];
  rec_t acc;
  int   n_cmp = 0, n_bad = 0, n_ev = 0;
  bit   mon_en = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp_v);
    end
  endtask

  // Instruction-level model: a wait count of 16 or more means the access times out.
  function automatic rec_t model(input logic [5:0] op, input int fw, input int mw);
    rec_t r;
    int   f, m;
    bit   mto;
    r = '{default: 0};
    f = (fw >= 16) ? 16 : fw + 1;
    r.mem_read = f;
    r.src_b    = f;
    r.cycles   = f;
    if (fw >= 16) begin
      r.ev = 4; r.last_state = int'(StFetch);
      return r;
    end
    r.ir_write = 1; r.pc_write = 1; r.cycles += 1; r.src_b += 3;
    mto = (mw >= 16);
    m   = mto ? 16 : mw + 1;
    case (op)
      OpLw, OpSw: begin
        r.cycles += 1 + m; r.alu_src_a = 1; r.src_b += 2; r.i_or_d = m;
        if (op == OpLw) begin
          r.mem_read += m;
          if (mto) begin
            r.ev = 4; r.last_state = int'(StMemRead);
          end else begin
            r.cycles += 1; r.reg_write = 1; r.mem_to_reg = 1; r.ev = 1;
            r.last_state = int'(StMemWb);
          end
        end else begin
          r.mem_write = m; r.ev = mto ? 4 : 1; r.last_state = int'(StMemWrite);
        end
      end
      OpRtype: begin
        r.cycles += 2; r.alu_src_a = 1; r.alu_op = 2; r.reg_write = 1; r.reg_dst = 1;
        r.ev = 1; r.last_state = int'(StRWb);
      end
      OpAddi: begin
        r.cycles += 2; r.alu_src_a = 1; r.src_b += 2; r.reg_write = 1;
        r.ev = 1; r.last_state = int'(StIWb);
      end
      OpBeq: begin
        r.cycles += 1; r.alu_src_a = 1; r.alu_op = 1; r.pc_write_cond = 1; r.pc_src = 1;
        r.ev = 1; r.last_state = int'(StBranch);
      end
      OpJ: begin
        r.cycles += 1; r.pc_write += 1; r.pc_src = 2; r.ev = 1; r.last_state = int'(StJump);
      end
      default: begin
        r.ev = 2; r.last_state = int'(StDecode);
      end
    endcase
    return r;
  endfunction

  // Monitor: accumulate output activity, compare on each instruction-ending pulse.
  initial begin
    rec_t e;
    string p;
    acc = '{default: 0};
    forever begin
      @(negedge clock);
      if (!mon_en) begin
        acc = '{default: 0};
      end else begin
        acc.cycles++;
        acc.mem_read += int'(mem_read);   acc.i_or_d += int'(i_or_d);
        acc.mem_write += int'(mem_write); acc.ir_write += int'(ir_write);
        acc.pc_write += int'(pc_write);   acc.pc_write_cond += int'(pc_write_cond);
        acc.reg_write += int'(reg_write); acc.mem_to_reg += int'(mem_to_reg);
        acc.reg_dst += int'(reg_dst);     acc.alu_src_a += int'(alu_src_a);
        acc.src_b += int'(alu_src_b);     acc.alu_op += int'(alu_op);
        acc.pc_src += int'(pc_source);
        if (instr_done || illegal_op || mem_fault) begin
          acc.ev = int'({mem_fault, illegal_op, instr_done});
          acc.last_state = int'(state);
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event: actual ev %0d required none", acc.ev);
          end else begin
            e = q.pop_front();
            p = $sformatf("i%0d.", n_ev);
            check({p, "event"}, acc.ev, e.ev);
            check({p, "cycles"}, acc.cycles, e.cycles);
            check({p, "state"}, acc.last_state, e.last_state);
            check({p, "mem_read"}, acc.mem_read, e.mem_read);
            check({p, "i_or_d"}, acc.i_or_d, e.i_or_d);
            check({p, "mem_write"}, acc.mem_write, e.mem_write);
            check({p, "ir_write"}, acc.ir_write, e.ir_write);
            check({p, "pc_write"}, acc.pc_write, e.pc_write);
            check({p, "pc_write_cond"}, acc.pc_write_cond, e.pc_write_cond);
            check({p, "reg_write"}, acc.reg_write, e.reg_write);
            check({p, "mem_to_reg"}, acc.mem_to_reg, e.mem_to_reg);
            check({p, "reg_dst"}, acc.reg_dst, e.reg_dst);
            check({p, "alu_src_a"}, acc.alu_src_a, e.alu_src_a);
            check({p, "alu_src_b"}, acc.src_b, e.src_b);
            check({p, "alu_op"}, acc.alu_op, e.alu_op);
            check({p, "pc_source"}, acc.pc_src, e.pc_src);
          end
          n_ev++;
          acc = '{default: 0};
        end
      end
    end
  end

  task automatic drive(input logic [5:0] op, input logic rdy);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    opcode    = op;
    mem_ready = rdy;
  endtask

  task automatic rand_drive(input logic [5:0] op);
    drive(op, 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_phase(input logic [5:0] op, input int w);
    if (w >= 16) begin
      repeat (16) drive(op, 1'b0);
    end else begin
      repeat (w) drive(op, 1'b0);
      drive(op, 1'b1);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    q.push_back(model(op, fw, mw));
    if (fw >= 16) begin
      repeat (16) drive(6'($urandom), 1'b0);
      return;
    end
    repeat (fw) drive(6'($urandom), 1'b0);
    drive(op, 1'b1);
    rand_drive(op);
    case (op)
      OpLw, OpSw: begin
        rand_drive(op);
        wait_phase(op, mw);
        if (op == OpLw && mw < 16) rand_drive(op);
      end
      OpRtype, OpAddi: repeat (2) rand_drive(op);
      OpBeq, OpJ:      rand_drive(op);
      default: ;
    endcase
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 10) return int'($urandom_range(0, 3));
    if (r < 13) return 15;
    if (r == 13) return 16;
    return 1;
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = OpRtype;
      1: op = OpLw;
      2: op = OpSw;
      3: op = OpBeq;
      4: op = OpJ;
      5: op = OpAddi;
      default: begin
        op = 6'($urandom);
        while (op == OpRtype || op == OpLw || op == OpSw || op == OpBeq || op == OpJ ||
               op == OpAddi) op = 6'($urandom);
      end
    endcase
    return op;
  endfunction

  initial begin
    reset = 1'b1; mem_ready = 1'b1; opcode = OpLw;
    repeat (3) begin
      @(negedge clock);
      check("reset_outputs", int'(outs), 0);
    end
    #1 mon_en = 1'b1;

    run_instr(OpLw, 0, 0);
    run_instr(OpSw, 0, 2);
    run_instr(OpBeq, 0, 0);
    run_instr(OpJ, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(OpRtype, 16, 0);
    run_instr(OpRtype, 16, 0);
    run_instr(OpLw, 15, 15);
    run_instr(OpSw, 1, 16);
    run_instr(OpAddi, 2, 0);

    @(negedge clock);
    #1 mon_en = 1'b0;
    check("sb_drain_pre_reset", q.size(), 0);

    drive(OpRtype, 1'b1);
    drive(OpRtype, 1'b0);
    drive(OpRtype, 1'b0);
    #1;
    check("exec_r_state", int'(state), int'(StExecR));
    check("exec_r_alu_op", int'(alu_op), 2);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", int'(outs), 0);
    repeat (2) begin
      @(negedge clock);
      check("no_r_wb_write", int'(reg_write), 0);
      check("reset_held_outputs", int'(outs), 0);
    end
    #1 mon_en = 1'b1;

    for (int i = 0; i < 150; i++) run_instr(pick_op(), pick_wait(), pick_wait());

    @(negedge clock);
    #1;
    check("sb_drain_final", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Finite-state controller that sequences the processor datapath over multiple clock cycles per instruction, replacing the single-cycle combinational opcode decoder. It takes the opcode from the instruction register and a ready handshake from the shared instruction/data memory. Each cycle it drives the datapath mux selects, register/PC/IR write enables, memory strobes and ALU operation class. It also flags illegal opcodes and memory timeouts.

## Interface
- WAIT_LIMIT, 15: maximum consecutive cycles a memory state waits for mem_ready before declaring a fault (4-bit wait counter).

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  instruction[31:26] from instruction register.
- mem_ready  in  1  memory completes current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU out.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  register write data: 0 = ALU out, 1 = MDR.
- reg_dst  out  1  destination: 0 = rt, 1 = rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = reg A.
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
- pc_source  out  2  00 = ALU result, 01 = ALU out reg, 10 = jump target.
- instr_done  out  1  one-cycle pulse on an instruction's final cycle.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- mem_fault  out  1  one-cycle pulse on a wait timeout.
- state  out  4  current state encoding, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States and transitions:
  - FETCH: wait for mem_ready -> DECODE.
  - DECODE:
    - lw/sw -> MEM_ADDR.
    - R-type -> EXEC_R.
    - addi -> EXEC_I.
    - beq -> BRANCH.
    - j -> JUMP.
    - other -> FETCH with illegal_op.
  - MEM_ADDR: lw -> MEM_READ; sw -> MEM_WRITE.
  - MEM_READ: wait for mem_ready -> MEM_WB.
  - MEM_WB, MEM_WRITE (on ready), R_WB, I_WB, BRANCH, JUMP: -> FETCH.
  - EXEC_R -> R_WB.
  - EXEC_I -> I_WB.
- Outputs are Moore-decoded from state, except ready-gated enables:
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write assert only when mem_ready=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALU out).
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WRITE: mem_write=1, i_or_d=1.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00.
  - I_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
- Any output not listed for a state is 0.
- instr_done asserts in these states:
  - MEM_WB, R_WB, I_WB, BRANCH, JUMP.
  - MEM_WRITE when mem_ready=1.
- Wait counter:
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - Increments each cycle in one of those states with mem_ready=0.
  - On reaching WAIT_LIMIT with mem_ready still 0: pulse mem_fault, go to FETCH. PC and IR are not written.
- mem_ready in the same cycle as the limit takes priority; the access completes normally.
- mem_ready is ignored in non-memory states.

## Timing
- Reset is asynchronous:
  - While asserted, state=FETCH, wait counter=0, and every output=0, including the Moore-decoded ones.
  - The first FETCH strobe appears the cycle after deassertion.
  - Reset mid-instruction abandons it; no partial write occurs after assertion.
- Latency with zero wait states:
  - lw 5 cycles; sw, R-type, addi 4; beq, j 3.
  - Each mem_ready=0 cycle adds one.
- opcode is sampled only in DECODE and MEM_ADDR; it must be stable from the IR load until FETCH.

## Structure
- Shared package mips_ctrl_pkg holds:
  - State enum.
  - Opcode constants.
  - alu_op, alu_src_b and pc_source encodings.
- The existing ALU control block consumes alu_op unchanged.
- One natural sub-module: multicycle_ctrl_decode, a purely combinational state-to-control-word decoder. The top holds the state register, the wait counter and the ready gating.

## Test plan
- Reset held 3 cycles, mem_ready=1, opcode=100011 -> all outputs 0 during reset. After release, states 0→1→2→3→4 with reg_write=1, mem_to_reg=1 in cycle 5; instr_done pulses once.
- sw (101011) with mem_ready low for 2 cycles in MEM_WRITE -> mem_write held 3 cycles, instr_done only on the ready cycle, total 6 cycles.
- beq (000100) then j (000010) -> 3 cycles each. BRANCH drives alu_op=01, pc_write_cond=1; JUMP drives pc_write=1, pc_source=10.
- opcode=111111 -> illegal_op pulses in DECODE; next state FETCH; no reg_write, mem_write or pc_write beyond FETCH.
- mem_ready stuck 0 in FETCH -> mem_fault pulses after 15 wait cycles, ir_write never asserts, FETCH re-entered with counter cleared.
- Async reset asserted mid-EXEC_R -> outputs drop to 0 immediately without a clock edge; no R_WB write follows.
